// File: rtl/edc_scrubber.sv
// -----------------------------------------------------------------------------
// edc_scrubber
//
// Background scrubber and arbiter between the CPU-side Wishbone master and the
// EDC-protected memory port. CPU traffic and periodic scrub reads share the one
// memory port. A scrub read that the corrector flags as corrected is followed by
// a write of the corrected word back to the same address. The first
// uncorrectable scrub error is logged until software clears it.
//
// Optional feature macro: EDC_SCRUB_STATS_EN
//   defined   -> saturating corrected/uncorrectable scrub error counters
//   undefined -> no counter registers, o_ce_count/o_ue_count tied to 0
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_mem_ctrl            scrub range: 0 = 128MB, 1 = 32MB
//   i_scrub_en            enables the scrub interval timer
//   i_m_*                 CPU Wishbone request (adr/sel/we/dat/cyc/stb)
//   o_m_dat/ack/err       CPU Wishbone response
//   o_s_*                 request to the EDC memory (adr/sel/we/dat/cyc/stb)
//   i_s_dat/ack/err       EDC memory response (err = uncorrectable)
//   i_s_ce                corrected-error flag, valid with i_s_ack
//   o_busy                scrub read or writeback in progress
//   o_pass_done           one-cycle pulse when the scrub address wraps
//   o_ue_valid, o_ue_adr  uncorrectable-error log
//   i_ue_clr              clears o_ue_valid
//   o_ce_count, o_ue_count  scrub error statistics
// -----------------------------------------------------------------------------
module edc_scrubber #(
    parameter int WB_DWIDTH      = 32,
    parameter int WB_SWIDTH      = 4,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_ctrl,
    input  logic                 i_scrub_en,
    input  logic [31:0]          i_m_adr,
    input  logic [WB_SWIDTH-1:0] i_m_sel,
    input  logic                 i_m_we,
    input  logic [WB_DWIDTH-1:0] i_m_dat,
    input  logic                 i_m_cyc,
    input  logic                 i_m_stb,
    output logic [WB_DWIDTH-1:0] o_m_dat,
    output logic                 o_m_ack,
    output logic                 o_m_err,
    output logic [31:0]          o_s_adr,
    output logic [WB_SWIDTH-1:0] o_s_sel,
    output logic                 o_s_we,
    output logic [WB_DWIDTH-1:0] o_s_dat,
    output logic                 o_s_cyc,
    output logic                 o_s_stb,
    input  logic [WB_DWIDTH-1:0] i_s_dat,
    input  logic                 i_s_ack,
    input  logic                 i_s_err,
    input  logic                 i_s_ce,
    output logic                 o_busy,
    output logic                 o_pass_done,
    output logic                 o_ue_valid,
    output logic [31:0]          o_ue_adr,
    input  logic                 i_ue_clr,
    output logic [CNT_WIDTH-1:0] o_ce_count,
    output logic [CNT_WIDTH-1:0] o_ue_count
);

    localparam int          TMR_W      = $clog2(SCRUB_INTERVAL);
    localparam logic [31:0] LIMIT_128M = 32'h07FF_FFFC;
    localparam logic [31:0] LIMIT_32M  = 32'h01FF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        SCRUB_RD,
        SCRUB_WB
    } state_t;

    state_t               r_state;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_scrub_pend;
    logic [31:0]          r_scrub_adr;
    logic [WB_DWIDTH-1:0] r_wb_dat;
    logic                 r_busy;
    logic                 r_pass_done;
    logic                 r_ue_valid;
    logic [31:0]          r_ue_adr;

    logic                 w_cpu_req;
    logic                 w_timer_exp;
    logic [31:0]          w_limit;
    logic                 w_wrap;
    logic                 w_advance;
    logic                 w_ue_hit;
    logic [31:0]          w_scrub_adr_nxt;

    assign w_cpu_req   = i_m_cyc & i_m_stb;
    assign w_timer_exp = i_scrub_en && (r_timer == TMR_W'(SCRUB_INTERVAL - 1));
    assign w_limit     = i_mem_ctrl ? LIMIT_32M : LIMIT_128M;
    // Compare against the limit before advancing, so an address already past
    // the 32MB limit (range switched mid-pass) also wraps on its next advance.
    assign w_wrap      = (r_scrub_adr >= w_limit);

    // Uncorrectable scrub read; ack takes priority if both arrive together.
    assign w_ue_hit  = (r_state == SCRUB_RD) && !i_s_ack && i_s_err;
    // A scrubbed word is finished after a clean read, an uncorrectable read,
    // or the end of its writeback.
    assign w_advance = ((r_state == SCRUB_RD) && i_s_ack && !i_s_ce) ||
                       w_ue_hit ||
                       ((r_state == SCRUB_WB) && (i_s_ack || i_s_err));

    assign w_scrub_adr_nxt = !w_advance ? r_scrub_adr :
                             w_wrap     ? 32'h0 :
                                          {r_scrub_adr[31:2] + 30'd1, 2'b00};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register regardless of order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer     <= '0;
            r_scrub_adr <= 32'h0;
        end else begin
            r_scrub_adr <= w_scrub_adr_nxt;
            if (!i_scrub_en || w_timer_exp) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Arbiter / scrub sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_scrub_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_pass_done  <= 1'b0;
        end else begin
            r_pass_done <= w_advance && w_wrap;
            case (r_state)
                IDLE: begin
                    // CPU always wins a tie with a pending scrub.
                    if (w_cpu_req) begin
                        r_state <= CPU;
                    end else if (r_scrub_pend) begin
                        r_state      <= SCRUB_RD;
                        r_busy       <= 1'b1;
                        r_scrub_pend <= 1'b0;
                    end
                end
                CPU: begin
                    if (i_s_ack || i_s_err) begin
                        r_state <= IDLE;
                    end
                end
                SCRUB_RD: begin
                    if (i_s_ack && i_s_ce) begin
                        r_state <= SCRUB_WB;
                    end else if (i_s_ack || i_s_err) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                SCRUB_WB: begin
                    if (i_s_ack || i_s_err) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A fresh expiry overrides the grant-clear above; only one scrub
            // is ever pending, further expiries are absorbed.
            if (w_timer_exp) begin
                r_scrub_pend <= 1'b1;
            end
        end
    end

    // NOTE: the corrected-word holding register is pure datapath and is always
    // loaded before it is used, so it deliberately has no reset.
    always_ff @(posedge i_clk) begin
        if ((r_state == SCRUB_RD) && i_s_ack) begin
            r_wb_dat <= i_s_dat;
        end
    end

    // First-error log: a clear in the same cycle as a new error re-arms the
    // log and captures the new address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ue_valid <= 1'b0;
            r_ue_adr   <= 32'h0;
        end else if (w_ue_hit && (!r_ue_valid || i_ue_clr)) begin
            r_ue_valid <= 1'b1;
            r_ue_adr   <= r_scrub_adr;
        end else if (i_ue_clr) begin
            r_ue_valid <= 1'b0;
        end
    end

`ifdef EDC_SCRUB_STATS_EN
    logic [CNT_WIDTH-1:0] r_ce_count;
    logic [CNT_WIDTH-1:0] r_ue_count;

    // Only scrub-path errors are counted; both counters saturate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ce_count <= '0;
            r_ue_count <= '0;
        end else begin
            if ((r_state == SCRUB_RD) && i_s_ack && i_s_ce && (r_ce_count != '1)) begin
                r_ce_count <= r_ce_count + 1'b1;
            end
            if (w_ue_hit && (r_ue_count != '1)) begin
                r_ue_count <= r_ue_count + 1'b1;
            end
        end
    end

    assign o_ce_count = r_ce_count;
    assign o_ue_count = r_ue_count;
`else
    assign o_ce_count = '0;
    assign o_ue_count = '0;
`endif

    // Memory-port mux. CPU traffic passes straight through; the CPU response
    // is suppressed whenever the port belongs to the scrubber.
    // NOTE: every output gets a default before the case so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        o_s_adr = 32'h0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        o_s_dat = '0;
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_m_dat = '0;
        o_m_ack = 1'b0;
        o_m_err = 1'b0;
        case (r_state)
            CPU: begin
                o_s_adr = i_m_adr;
                o_s_sel = i_m_sel;
                o_s_we  = i_m_we;
                o_s_dat = i_m_dat;
                o_s_cyc = i_m_cyc;
                o_s_stb = i_m_stb;
                o_m_dat = i_s_dat;
                o_m_ack = i_s_ack;
                o_m_err = i_s_err;
            end
            SCRUB_RD: begin
                o_s_adr = r_scrub_adr;
                o_s_sel = '1;
                o_s_cyc = 1'b1;
                o_s_stb = 1'b1;
            end
            SCRUB_WB: begin
                o_s_adr = r_scrub_adr;
                o_s_sel = '1;
                o_s_we  = 1'b1;
                o_s_dat = r_wb_dat;
                o_s_cyc = 1'b1;
                o_s_stb = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_pass_done = r_pass_done;
    assign o_ue_valid  = r_ue_valid;
    assign o_ue_adr    = r_ue_adr;

endmodule
